// File: rtl/ex_if.sv
// Decode-to-execute bus and execute-to-memory results for the MIPS execute stage.
// The master side (decode / bench) drives the operation; the slave side (ex) returns results.
interface ex_if;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        wreg_i;
    logic [4:0]  waddr_i;

    logic        wreg_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wreg_i, waddr_i,
        input  wreg_o, waddr_o, wdata_o, stallreq_o, hi_o, lo_o
    );

    modport slave (
        input  flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wreg_i, waddr_i,
        output wreg_o, waddr_o, wdata_o, stallreq_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex.sv
// MIPS execute stage: single-cycle logic/shift/arith/move ops, HI/LO registers and a
// 32-step restoring divider that stalls the pipeline while it iterates.
module ex (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);
    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;

    typedef enum logic [1:0] {
        DIV_FREE,
        DIV_BY_ZERO,
        DIV_ON,
        DIV_END
    } div_state_e;

    div_state_e  state, state_nxt;
    logic        stall;
    logic        is_div, div_signed;
    logic [31:0] hi, lo;
    logic [31:0] result;

    // Divider datapath: {remainder[64:33], unconsumed dividend / quotient bits[32:0]}
    logic [64:0] rem_q;
    logic [64:0] rem_q_step;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        neg_q, neg_r;
    logic [32:0] upper;
    logic [31:0] diff;
    logic [31:0] mag1, mag2;
    logic [31:0] quo_fix, rem_fix;

    assign is_div     = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
    assign div_signed = (bus.aluop_i == EXE_DIV_OP);
    assign mag1       = (div_signed && bus.reg1_i[31]) ? 32'd0 - bus.reg1_i : bus.reg1_i;
    assign mag2       = (div_signed && bus.reg2_i[31]) ? 32'd0 - bus.reg2_i : bus.reg2_i;

    // The partial remainder is always below the divisor, so the 33-bit trial fits and
    // the difference never needs more than 32 bits.
    assign upper      = rem_q[64:32];
    assign diff       = upper[31:0] - divisor;
    assign rem_q_step = (upper >= {1'b0, divisor}) ? {diff, rem_q[31:0], 1'b1}
                                                   : {rem_q[63:0], 1'b0};

    assign quo_fix = neg_q ? 32'd0 - rem_q[31:0]  : rem_q[31:0];
    assign rem_fix = neg_r ? 32'd0 - rem_q[64:33] : rem_q[64:33];

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            DIV_FREE: begin
                if (is_div) begin
                    stall     = 1'b1;
                    state_nxt = (bus.reg2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: state_nxt = DIV_FREE;
            DIV_ON: begin
                stall = is_div;
                if (cnt == 6'd31) state_nxt = DIV_END;
            end
            DIV_END: state_nxt = DIV_FREE;
        endcase
        if (bus.flush_i) begin
            state_nxt = DIV_FREE;
            stall     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_FREE;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (state == DIV_END && !bus.flush_i) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
        end
    end

    // NOTE: the divider datapath is left unreset; it is reloaded every cycle the FSM sits in
    // DIV_FREE and is only consumed after a full run from there.
    always_ff @(posedge clk) begin
        if (state == DIV_FREE) begin
            rem_q   <= {32'd0, mag1, 1'b0};
            divisor <= mag2;
            cnt     <= '0;
            neg_q   <= div_signed && (bus.reg1_i[31] ^ bus.reg2_i[31]);
            neg_r   <= div_signed && bus.reg1_i[31];
        end else if (state == DIV_ON) begin
            rem_q <= rem_q_step;
            cnt   <= cnt + 6'd1;
        end
    end

    always_comb begin
        result = '0;
        case (bus.alusel_i)
            EXE_RES_LOGIC: begin
                case (bus.aluop_i)
                    EXE_AND_OP: result = bus.reg1_i & bus.reg2_i;
                    EXE_OR_OP:  result = bus.reg1_i | bus.reg2_i;
                    EXE_XOR_OP: result = bus.reg1_i ^ bus.reg2_i;
                    EXE_NOR_OP: result = ~(bus.reg1_i | bus.reg2_i);
                    default:    result = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (bus.aluop_i)
                    EXE_SLL_OP: result = bus.reg2_i << bus.reg1_i[4:0];
                    EXE_SRL_OP: result = bus.reg2_i >> bus.reg1_i[4:0];
                    EXE_SRA_OP: result = $signed(bus.reg2_i) >>> bus.reg1_i[4:0];
                    default:    result = '0;
                endcase
            end
            EXE_RES_ARITHMETIC: begin
                case (bus.aluop_i)
                    EXE_ADDU_OP: result = bus.reg1_i + bus.reg2_i;
                    EXE_SUBU_OP: result = bus.reg1_i - bus.reg2_i;
                    EXE_SLT_OP:  result = {31'd0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
                    EXE_SLTU_OP: result = {31'd0, bus.reg1_i < bus.reg2_i};
                    default:     result = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (bus.aluop_i)
                    EXE_MFHI_OP: result = hi;
                    EXE_MFLO_OP: result = lo;
                    default:     result = '0;
                endcase
            end
            EXE_RES_NOP: result = '0;
            default:     result = '0;
        endcase
    end

    // Reset blanks every output so downstream never sees unreset HI/LO or a stale stall.
    assign bus.wreg_o     = !rst && !bus.flush_i && !is_div && bus.wreg_i;
    assign bus.waddr_o    = rst ? 5'd0 : bus.waddr_i;
    assign bus.wdata_o    = rst ? 32'd0 : result;
    assign bus.stallreq_o = !rst && stall;
    assign bus.hi_o       = rst ? 32'd0 : hi;
    assign bus.lo_o       = rst ? 32'd0 : lo;
endmodule
